// File: rtl/atm_keypad_pkg.sv
// atm_keypad_pkg: key codes, FSM state encoding and key classification helper
package atm_keypad_pkg;
    localparam logic [3:0] TECLA_ENTER    = 4'hA;
    localparam logic [3:0] TECLA_BORRAR   = 4'hB;
    localparam logic [3:0] TECLA_CANCELAR = 4'hC;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PIN   = 2'd1;
    localparam logic [1:0] ST_MONTO = 2'd2;
    function automatic logic es_digito(input logic [3:0] c);
        return c <= 4'd9;
    endfunction
endpackage

// File: rtl/atm_key_debounce.sv
// atm_key_debounce: accepts a key once after DEBOUNCE stable cycles, re-armed by release
module atm_key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_presionada,
    input  logic [3:0] tecla,
    output logic       tecla_ok,
    output logic [3:0] tecla_codigo
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE);
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic          r_armed;
    logic          r_ok;
    logic          w_same;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    assign w_same    = tecla_presionada && r_cnt != '0 && tecla == r_code;
    assign w_cnt_nxt = !tecla_presionada ? '0 : !w_same ? CW'(1) : r_cnt == DEB ? r_cnt : r_cnt + CW'(1);
    assign w_accept  = r_armed && tecla_presionada && w_cnt_nxt == DEB;
    // run-length counter, re-arm on release, one accept pulse per press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_code  <= 4'd0;
            r_armed <= 1'b1;
            r_ok    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_code  <= tecla;
            r_armed <= !tecla_presionada ? 1'b1 : w_accept ? 1'b0 : r_armed;
            r_ok    <= w_accept;
        end
    end
    assign tecla_ok     = r_ok;
    assign tecla_codigo = r_code;
endmodule

// File: rtl/atm_keypad_encoder.sv
// atm_keypad_encoder: ATM keypad front end (PIN digit forwarding, decimal amount entry).
// Optional inactivity timeout enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_encoder
    import atm_keypad_pkg::*;
#(
    parameter int DEBOUNCE         = 4,
    parameter int PIN_DIGITS       = 4,
    parameter int MAX_MONTO_DIGITS = 9
`ifdef KEYPAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tecla_presionada,
    input  logic [3:0]  tecla,
    input  logic        iniciar_pin,
    input  logic        iniciar_monto,
    output logic        digito_stb,
    output logic [3:0]  digito,
    output logic        monto_stb,
    output logic [31:0] monto,
    output logic        desbordamiento,
    output logic        ocupado
`ifdef KEYPAD_TIMEOUT_EN
    ,
    output logic        tiempo_agotado
`endif
);
    localparam int CMAX = (PIN_DIGITS > MAX_MONTO_DIGITS) ? PIN_DIGITS : MAX_MONTO_DIGITS;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PIN_LAST  = CW'(PIN_DIGITS - 1);
    localparam logic [CW-1:0] MONTO_MAX = CW'(MAX_MONTO_DIGITS);
    logic          w_ok;
    logic [3:0]    w_code;
    logic          w_timeout;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_acc;
    logic          r_digito_stb;
    logic [3:0]    r_digito;
    logic          r_monto_stb;
    logic [31:0]   r_monto;
    logic          r_ovf;
    atm_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk              (clk),
        .rst              (rst),
        .tecla_presionada (tecla_presionada),
        .tecla            (tecla),
        .tecla_ok         (w_ok),
        .tecla_codigo     (w_code)
    );
`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_to;
    assign w_timeout = r_state != ST_IDLE && !w_ok && r_to_cnt == TO_LAST;
    // inactivity counter: idle cycles inside a session, cleared by any accepted key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
            r_to     <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == ST_IDLE || w_ok || w_timeout) ? '0 : r_to_cnt + TW'(1);
            r_to     <= w_timeout;
        end
    end
    assign tiempo_agotado = r_to;
`else
    assign w_timeout = 1'b0;
`endif
    // session FSM, amount accumulator and registered strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= 32'd0;
            r_digito_stb <= 1'b0;
            r_digito     <= 4'd0;
            r_monto_stb  <= 1'b0;
            r_monto      <= 32'd0;
            r_ovf        <= 1'b0;
        end else begin
            r_digito_stb <= 1'b0;
            r_monto_stb  <= 1'b0;
            r_ovf        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iniciar_pin) begin
                        r_state <= ST_PIN;
                        r_cnt   <= '0;
                    end else if (iniciar_monto) begin
                        r_state <= ST_MONTO;
                        r_cnt   <= '0;
                        r_acc   <= 32'd0;
                    end
                end
                ST_PIN: begin
                    if (w_ok && es_digito(w_code)) begin
                        r_digito     <= w_code;
                        r_digito_stb <= 1'b1;
                        r_cnt        <= r_cnt + CW'(1);
                        if (r_cnt == PIN_LAST) r_state <= ST_IDLE;
                    end else if (w_ok && w_code == TECLA_CANCELAR) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MONTO: begin
                    if (w_ok && es_digito(w_code)) begin
                        if (r_cnt == MONTO_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= r_acc * 32'd10 + 32'(w_code);
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end else if (w_ok && w_code == TECLA_ENTER && r_cnt != '0) begin
                        r_monto     <= r_acc;
                        r_monto_stb <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_ok && w_code == TECLA_BORRAR) begin
                        r_acc <= 32'd0;
                        r_cnt <= '0;
                    end else if (w_ok && w_code == TECLA_CANCELAR) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_timeout) begin
                r_state <= ST_IDLE;
                r_acc   <= 32'd0;
            end
        end
    end
    assign digito_stb     = r_digito_stb;
    assign digito         = r_digito;
    assign monto_stb      = r_monto_stb;
    assign monto          = r_monto;
    assign desbordamiento = r_ovf;
    assign ocupado        = r_state != ST_IDLE;
endmodule

// File: tb/tb_atm_keypad_encoder.sv
// tb_atm_keypad_encoder: directed stimulus, session-level reference model compared every cycle
module tb_atm_keypad_encoder;
    localparam int DEB = 4, PIN = 4, MAXD = 9, TO = 50;
    logic        clk = 0, rst = 0, tecla_presionada = 0, iniciar_pin = 0, iniciar_monto = 0;
    logic [3:0]  tecla = 0;
    logic        digito_stb, monto_stb, desbordamiento, ocupado;
    logic [3:0]  digito;
    logic [31:0] monto;
`ifdef KEYPAD_TIMEOUT_EN
    logic        tiempo_agotado;
`endif
    int errors = 0, checks = 0;
    int n_d = 0, n_m = 0, n_o = 0, n_t = 0;
    always #5 clk = ~clk;
    atm_keypad_encoder #(.DEBOUNCE(DEB), .PIN_DIGITS(PIN), .MAX_MONTO_DIGITS(MAXD)
`ifdef KEYPAD_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .tecla_presionada(tecla_presionada), .tecla(tecla),
        .iniciar_pin(iniciar_pin), .iniciar_monto(iniciar_monto),
        .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto),
        .desbordamiento(desbordamiento), .ocupado(ocupado)
`ifdef KEYPAD_TIMEOUT_EN
        , .tiempo_agotado(tiempo_agotado)
`endif
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    // reference model: session mode + list of entered digits
    int mode, run, armed, last, acc_p, idle;
    int code_p;
    int q[$];
    logic e_d, e_m, e_o, e_t;
    logic [3:0] e_dig;
    logic [31:0] e_monto;
    always @(posedge clk) begin
        int m0;
        longint v;
        if (!rst) begin
            mode = 0; q.delete(); run = 0; armed = 1; last = 0; acc_p = 0; code_p = 0; idle = 0;
            e_d = 0; e_m = 0; e_o = 0; e_t = 0; e_dig = 0; e_monto = 0;
        end else begin
            e_d = 0; e_m = 0; e_o = 0; e_t = 0;
            m0 = mode;
            if (mode == 0) begin
                if (iniciar_pin) begin mode = 1; q.delete(); idle = 0; end
                else if (iniciar_monto) begin mode = 2; q.delete(); idle = 0; end
            end else if (acc_p != 0 && mode == 1) begin
                if (code_p <= 9) begin
                    e_d = 1; e_dig = 4'(code_p); q.push_back(code_p);
                    if (q.size() == PIN) mode = 0;
                end else if (code_p == 12) mode = 0;
            end else if (acc_p != 0 && mode == 2) begin
                if (code_p <= 9) begin
                    if (q.size() < MAXD) q.push_back(code_p); else e_o = 1;
                end else if (code_p == 10 && q.size() > 0) begin
                    v = 0;
                    foreach (q[i]) v = v * 10 + q[i];
                    e_monto = 32'(v); e_m = 1; mode = 0;
                end else if (code_p == 11) q.delete();
                else if (code_p == 12) mode = 0;
            end
`ifdef KEYPAD_TIMEOUT_EN
            if (m0 != 0) begin
                if (acc_p != 0) idle = 0;
                else begin
                    idle++;
                    if (idle == TO) begin mode = 0; e_t = 1; q.delete(); idle = 0; end
                end
            end
`endif
            if (!tecla_presionada) begin run = 0; armed = 1; end
            else if (run > 0 && int'(tecla) == last) run++;
            else run = 1;
            last = int'(tecla);
            acc_p = (tecla_presionada && armed != 0 && run == DEB) ? 1 : 0;
            if (acc_p != 0) armed = 0;
            code_p = int'(tecla);
        end
    end
    // per-cycle comparison and pulse tallies
    always @(negedge clk) begin
        n_d += int'(digito_stb); n_m += int'(monto_stb); n_o += int'(desbordamiento);
`ifdef KEYPAD_TIMEOUT_EN
        n_t += int'(tiempo_agotado);
`endif
        if (rst) begin
            chk("digito_stb", 32'(digito_stb), 32'(e_d));
            chk("digito", 32'(digito), 32'(e_dig));
            chk("monto_stb", 32'(monto_stb), 32'(e_m));
            chk("monto", monto, e_monto);
            chk("desbordamiento", 32'(desbordamiento), 32'(e_o));
            chk("ocupado", 32'(ocupado), 32'(mode != 0));
`ifdef KEYPAD_TIMEOUT_EN
            chk("tiempo_agotado", 32'(tiempo_agotado), 32'(e_t));
`endif
        end
    end
    task automatic key(input logic [3:0] c, input int hold);
        @(negedge clk); tecla = c; tecla_presionada = 1;
        repeat (hold) @(negedge clk);
        tecla_presionada = 0;
        repeat (3) @(negedge clk);
    endtask
    task automatic start(input logic p, input logic m);
        @(negedge clk); iniciar_pin = p; iniciar_monto = m;
        @(negedge clk); iniciar_pin = 0; iniciar_monto = 0;
    endtask
    task automatic reset_zero(input string tag);
        chk({tag, "_digito_stb"}, 32'(digito_stb), 0);
        chk({tag, "_digito"}, 32'(digito), 0);
        chk({tag, "_monto_stb"}, 32'(monto_stb), 0);
        chk({tag, "_monto"}, monto, 0);
        chk({tag, "_desb"}, 32'(desbordamiento), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
    endtask
    initial begin
        int m_before;
        #12 reset_zero("por");
        @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        start(1, 0);
        key(4'd4, 6); key(4'd7, 6); key(4'd5, 6); key(4'd6, 6);
        chk("pin_count", 32'(n_d), 4);
        chk("pin_last", 32'(digito), 6);
        chk("pin_idle", 32'(ocupado), 0);
        start(0, 1);
        key(4'd1, 6); key(4'd5, 6); key(4'hE, 6); key(4'd0, 6); key(4'd0, 6); key(4'hA, 6);
        chk("monto_1500", monto, 1500);
        chk("monto_stb_count", 32'(n_m), 1);
        start(0, 1);
        key(4'd1, 6); key(4'd5, 6); key(4'hB, 6); key(4'd2, 6); key(4'hA, 6);
        chk("monto_borrar", monto, 2);
        start(0, 1);
        repeat (10) key(4'd9, 6);
        key(4'hA, 6);
        chk("ovf_count", 32'(n_o), 1);
        chk("monto_max", monto, 999999999);
        start(1, 0);
        key(4'd3, 2);
        chk("bounce", 32'(n_d), 4);
        key(4'hC, 6);
        chk("pin_cancel", 32'(ocupado), 0);
        start(0, 1);
        key(4'd8, 6); key(4'hC, 6);
        chk("cancel_hold", monto, 999999999);
        chk("cancel_idle", 32'(ocupado), 0);
        start(1, 1);
        start(0, 1);
        key(4'd9, 6);
        chk("both_pin", 32'(digito), 9);
        chk("both_cnt", 32'(n_d), 5);
        key(4'hC, 6);
        start(0, 1);
        key(4'd1, 6); key(4'd2, 6);
        m_before = n_m;
        @(negedge clk); #1 rst = 0;
        #1 reset_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1;
        key(4'hA, 6);
        chk("rst_no_stb", 32'(n_m), 32'(m_before));
        chk("rst_monto", monto, 0);
`ifdef KEYPAD_TIMEOUT_EN
        start(0, 1);
        key(4'd7, 6);
        repeat (55) @(negedge clk);
        chk("to_count", 32'(n_t), 1);
        chk("to_idle", 32'(ocupado), 0);
        chk("to_no_stb", 32'(n_m), 32'(m_before));
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/atm_keypad_encoder.md
Name: atm_keypad_encoder

Overview:
Keypad front end for the ATM datapath; the producing end of the digit/amount strobe interface the ATM controller consumes.
- Debounces raw key presses.
- In PIN mode, forwards each digit as a one-cycle digito_stb pulse with digito.
- In amount mode, accumulates decimal digits into a binary value and emits it on ENTER as a one-cycle monto_stb pulse with monto.

Parameters:
DEBOUNCE, 4, consecutive stable cycles required to accept a press (>=1)
PIN_DIGITS, 4, digits forwarded per PIN session
MAX_MONTO_DIGITS, 9, max decimal digits accepted for an amount (999999999 fits 32 bits)
TIMEOUT_CYCLES, 1000000, inactivity limit (only with KEYPAD_TIMEOUT_EN)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
tecla_presionada  input  1  raw key-down level from keypad
tecla  input  4  raw key code: 0-9 digit, 0xA ENTER, 0xB BORRAR (clear), 0xC CANCELAR; others ignored
iniciar_pin  input  1  one-cycle request to start a PIN session
iniciar_monto  input  1  one-cycle request to start an amount session
digito_stb  output  1  one-cycle pulse per forwarded PIN digit
digito  output  4  last forwarded PIN digit, held until next strobe
monto_stb  output  1  one-cycle pulse when amount is committed
monto  output  32  committed amount in binary, held until next commit
desbordamiento  output  1  one-cycle pulse when a digit is dropped for exceeding MAX_MONTO_DIGITS
ocupado  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; accumulator, digit counter and debounce counter cleared.
- Reset mid-session discards the session; no strobe is issued.
- Debounce:
  - The counter counts consecutive cycles with tecla_presionada=1 and tecla unchanged.
  - A code change or release restarts the count.
  - The press is accepted when the count reaches DEBOUNCE, with an internal one-cycle pulse.
  - Only one accept per press; a release (tecla_presionada=0 for >=1 cycle) is required to re-arm.
- Latency: accept pulse in cycle N -> digito_stb/monto_stb/desbordamiento high in cycle N+1 (registered outputs).
- States: IDLE, PIN, MONTO.
- IDLE:
  - iniciar_pin -> PIN, with digit counter cleared.
  - iniciar_monto -> MONTO, with accumulator and counter cleared.
  - Both asserted together -> PIN wins.
  - Accepted keys are ignored.
- PIN:
  - Accepted digit 0-9 -> digito=code, digito_stb pulse, count+1.
  - When count reaches PIN_DIGITS, return to IDLE on that same edge.
  - ENTER and BORRAR are ignored.
  - CANCELAR -> IDLE, no pulse.
- MONTO:
  - Accepted digit with count<MAX_MONTO_DIGITS -> acc = acc*10 + code (32-bit, no wrap possible within limit), count+1.
  - Accepted digit with count==MAX_MONTO_DIGITS -> digit dropped, desbordamiento pulse.
  - ENTER with count>=1 -> monto=acc, monto_stb pulse, IDLE.
  - ENTER with count==0 -> ignored.
  - BORRAR -> acc=0, count=0, stay in MONTO.
  - CANCELAR -> IDLE, monto unchanged, no pulse.
- iniciar_* outside IDLE is ignored.
- Invalid codes (0xD-0xF) are debounced but produce no action in any state.
- digito_stb and monto_stb are never high in the same cycle.

Optional Feature:
KEYPAD_TIMEOUT_EN
- Defined:
  - An inactivity counter runs in PIN/MONTO and restarts on every accepted key.
  - Reaching TIMEOUT_CYCLES forces IDLE, clears the accumulator, and pulses an extra output tiempo_agotado (1 bit, reset 0) for one cycle.
- Undefined: no counter; the tiempo_agotado port is absent; sessions wait indefinitely.

Decomposition:
- Package atm_keypad_pkg holds:
  - key code constants (TECLA_ENTER=4'hA, TECLA_BORRAR=4'hB, TECLA_CANCELAR=4'hC)
  - state encoding (IDLE=0, PIN=1, MONTO=2)
- Sub-module atm_key_debounce (clk, rst, tecla_presionada, tecla -> tecla_ok pulse, tecla_codigo) holds the debounce counter and re-arm logic.
- The top level holds the FSM, accumulator and output registers.

Test Plan:
- Reset: rst low mid-MONTO after keys 1,2 -> all outputs 0, ocupado 0; a later ENTER produces no monto_stb.
- PIN entry (DEBOUNCE=4): iniciar_pin, keys 4,7,5,6 each held 6 cycles -> four digito_stb pulses with digito 4,7,5,6 in order, each 1 cycle after accept; IDLE after the 4th.
- Amount: iniciar_monto, keys 1,5,0,0, ENTER -> single monto_stb with monto=1500; BORRAR after "1,5" then 2, ENTER -> monto=2.
- Overflow: iniciar_monto, ten '9' keys, ENTER -> one desbordamiento pulse on the 10th; monto=999999999.
- Bounce and cancel: key 3 held only 2 cycles -> no strobe; CANCELAR in MONTO -> IDLE, monto holds the previous value; iniciar_pin and iniciar_monto together -> PIN.
- Timeout (KEYPAD_TIMEOUT_EN, TIMEOUT_CYCLES=50): iniciar_monto, key 7, 50 idle cycles -> tiempo_agotado pulse, ocupado 0, no monto_stb.
